// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and the multi-cycle sequencer that drives it.
package alu_pkg;

  // ALUOp encodings understood by the shared 8-bit ALU
  localparam logic [2:0] ALU_LD  = 3'b000;
  localparam logic [2:0] ALU_SHR = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b100;

  // Extended operations run by the sequencer
  typedef enum logic [1:0] {
    ADD16 = 2'b00,
    XOR16 = 2'b01,
    MUL8  = 2'b10,
    RSVD  = 2'b11
  } seq_op_t;

  // Sequencer states
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LO   = 3'd1,
    HI   = 3'd2,
    MUL  = 3'd3,
    DONE = 3'd4
  } seq_state_t;

endpackage

// File: rtl/alu_seq.sv
// Multi-cycle sequencer: runs 16-bit ADD/XOR and 8x8 shift-add multiply
// on the shared 8-bit combinational ALU, owning its inputs while busy.
import alu_pkg::*;

module alu_seq #(
  parameter int MUL_ITER = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [15:0] a_in,
  input  logic [15:0] b_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        carry_flag,
  output logic        err,
  output logic [2:0]  alu_op,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic        alu_cin,
  input  logic [7:0]  alu_rslt,
  input  logic        alu_cout
);

  localparam int CNT_W = $clog2(MUL_ITER + 1);

  seq_state_t  state_reg, state_next;
  seq_op_t     op_reg;
  logic [15:0] a_reg, b_reg;
  logic [7:0]  hi_reg, lo_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic        c_reg;
  logic [15:0] result_reg;
  logic        carry_reg;
  logic        err_reg;

  // Product register after the current shift-add step
  logic [15:0] p_step;
  assign p_step = {alu_cout, alu_rslt, lo_reg[7:1]};

  // The last multiply iteration is the one where the counter goes 1 -> 0
  logic mul_last;
  assign mul_last = (cnt_reg == CNT_W'(1));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic and ALU drive; ALU inputs are parked at zero when idle
  always_comb begin
    state_next = state_reg;
    alu_op     = ALU_LD;
    alu_a      = 8'h00;
    alu_b      = 8'h00;
    alu_cin    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (op == 2'b10)      state_next = MUL;
          else if (op == 2'b11) state_next = DONE;
          else                  state_next = LO;
        end
      end
      LO: begin
        alu_op     = (op_reg == XOR16) ? ALU_XOR : ALU_ADD;
        alu_a      = a_reg[7:0];
        alu_b      = b_reg[7:0];
        state_next = HI;
      end
      HI: begin
        alu_op     = (op_reg == XOR16) ? ALU_XOR : ALU_ADD;
        alu_a      = a_reg[15:8];
        alu_b      = b_reg[15:8];
        alu_cin    = (op_reg == ADD16) ? c_reg : 1'b0;
        state_next = DONE;
      end
      MUL: begin
        alu_op = ALU_ADD;
        alu_a  = hi_reg;
        alu_b  = lo_reg[0] ? a_reg[7:0] : 8'h00;
        if (mul_last) state_next = DONE;
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand latch, partial products and completion results
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_reg     <= ADD16;
      a_reg      <= 16'h0000;
      b_reg      <= 16'h0000;
      hi_reg     <= 8'h00;
      lo_reg     <= 8'h00;
      cnt_reg    <= '0;
      c_reg      <= 1'b0;
      result_reg <= 16'h0000;
      carry_reg  <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_reg   <= a_in;
            b_reg   <= b_in;
            op_reg  <= seq_op_t'(op);
            err_reg <= (op == 2'b11);
            hi_reg  <= 8'h00;
            lo_reg  <= b_in[7:0];
            cnt_reg <= CNT_W'(MUL_ITER);
            c_reg   <= 1'b0;
            // Reserved op completes immediately with a zero result
            if (op == 2'b11) begin
              result_reg <= 16'h0000;
              carry_reg  <= 1'b0;
            end
          end
        end
        LO: begin
          result_reg[7:0] <= alu_rslt;
          c_reg           <= alu_cout;
        end
        HI: begin
          result_reg[15:8] <= alu_rslt;
          carry_reg        <= (op_reg == ADD16) ? alu_cout : 1'b0;
        end
        MUL: begin
          {hi_reg, lo_reg} <= p_step;
          cnt_reg          <= cnt_reg - CNT_W'(1);
          if (mul_last) begin
            result_reg <= p_step;
            carry_reg  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy       = (state_reg != IDLE);
  assign done       = (state_reg == DONE);
  assign result     = result_reg;
  assign carry_flag = carry_reg;
  assign err        = err_reg;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with a behavioural model of the shared ALU.
module tb_alu_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [15:0] a_in, b_in;
  logic        busy, done, carry_flag, err;
  logic [15:0] result;
  logic [2:0]  alu_op;
  logic [7:0]  alu_a, alu_b, alu_rslt;
  logic        alu_cin, alu_cout;

  int checks_total;
  int checks_passed;

  alu_seq #(.MUL_ITER(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .a_in(a_in), .b_in(b_in), .busy(busy), .done(done),
    .result(result), .carry_flag(carry_flag), .err(err),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_rslt(alu_rslt), .alu_cout(alu_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared 8-bit combinational ALU
  logic [8:0] alu_sum;
  always_comb begin
    alu_sum  = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_cin};
    alu_rslt = 8'h00;
    alu_cout = 1'b0;
    case (alu_op)
      3'b000: alu_rslt = alu_a;
      3'b001: begin alu_rslt = {1'b0, alu_a[7:1]}; alu_cout = alu_a[0]; end
      3'b010: begin alu_rslt = alu_sum[7:0]; alu_cout = alu_sum[8]; end
      3'b100: alu_rslt = alu_a ^ alu_b;
      default: ;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        cy;
    logic        er;
    int          lat;
    logic        cin_hi;
  } vec_t;

  // Launch one operation and watch it to completion.
  // The k-th negedge after the accepting edge observes cycle T+k.
  task automatic run_op(input vec_t v, input string tag);
    int   lat_obs;
    int   done_cnt;
    logic busy_ok;
    logic cin2;
    lat_obs  = 0;
    done_cnt = 0;
    busy_ok  = 1'b1;
    cin2     = 1'b0;
    op    = v.op;
    a_in  = v.a;
    b_in  = v.b;
    start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 2) cin2 = alu_cin;
      if (lat_obs == 0 && !busy) busy_ok = 1'b0;
      if (done) begin
        done_cnt++;
        if (lat_obs == 0) begin
          lat_obs = k;
          check({tag, " result"}, 32'(result), 32'(v.res));
          check({tag, " carry"},  32'(carry_flag), 32'(v.cy));
          check({tag, " err"},    32'(err), 32'(v.er));
        end
      end
      if (lat_obs != 0 && k == lat_obs + 1) begin
        check({tag, " busy_after"}, 32'(busy), 32'd0);
        break;
      end
    end
    check({tag, " latency"}, 32'(lat_obs), 32'(v.lat));
    check({tag, " busy_held"}, 32'(busy_ok), 32'd1);
    check({tag, " done_count"}, 32'(done_cnt), 32'd1);
    if (v.op == 2'b00 || v.op == 2'b01) check({tag, " alu_cin_hi"}, 32'(cin2), 32'(v.cin_hi));
    $display("%s op=%0d a=%04h b=%04h -> result=%04h carry=%0b err=%0b latency=%0d",
             tag, v.op, v.a, v.b, result, carry_flag, err, lat_obs);
  endtask

  vec_t vecs[7];

  initial begin
    vec_t v;
    int   dcnt;
    checks_total  = 0;
    checks_passed = 0;

    vecs[0] = '{2'b00, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0, 3, 1'b1};
    vecs[1] = '{2'b00, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0, 3, 1'b1};
    vecs[2] = '{2'b11, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b1, 1, 1'b0};
    vecs[3] = '{2'b01, 16'hA5A5, 16'h0FF0, 16'hAA55, 1'b0, 1'b0, 3, 1'b0};
    vecs[4] = '{2'b10, 16'h00FF, 16'h00FF, 16'hFE01, 1'b0, 1'b0, 9, 1'b0};
    vecs[5] = '{2'b10, 16'h000D, 16'h000B, 16'h008F, 1'b0, 1'b0, 9, 1'b0};
    vecs[6] = '{2'b00, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0, 3, 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    a_in  = 16'h0000;
    b_in  = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset busy",   32'(busy), 32'd0);
    check("reset done",   32'(done), 32'd0);
    check("reset result", 32'(result), 32'd0);
    check("reset carry",  32'(carry_flag), 32'd0);
    check("reset err",    32'(err), 32'd0);
    check("reset alu_op", 32'(alu_op), 32'd0);
    $display("reset: busy=%0b done=%0b result=%04h", busy, done, result);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
      @(negedge clk);
    end

    // Start pulses and operand changes while a multiply runs
    op = 2'b10; a_in = 16'h000D; b_in = 16'h000B; start = 1'b1;
    @(posedge clk);
    dcnt = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k >= 2 && k <= 9) begin
        start = 1'b1; op = 2'b00; a_in = 16'hFFFF; b_in = 16'hFFFF;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        dcnt++;
        check("mul_ignore latency", 32'(k), 32'd9);
        check("mul_ignore result", 32'(result), 32'h008F);
      end
    end
    check("mul_ignore done_count", 32'(dcnt), 32'd1);
    $display("mul_ignore: result=%04h dones=%0d", result, dcnt);
    @(negedge clk);

    // Reset in the middle of a multiply
    op = 2'b10; a_in = 16'h00FF; b_in = 16'h00FF; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;           // sampled by the edge at T+4
    @(negedge clk);
    check("midreset busy",   32'(busy), 32'd0);
    check("midreset result", 32'(result), 32'd0);
    check("midreset done",   32'(done), 32'd0);
    rst_n = 1'b1;
    dcnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("midreset no_done", 32'(dcnt), 32'd0);
    $display("midreset: busy=%0b result=%04h dones=%0d", busy, result, dcnt);

    v = '{2'b00, 16'h8001, 16'h8001, 16'h0002, 1'b1, 1'b0, 3, 1'b0};
    run_op(v, "post_reset");

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
